// File: rtl/detector_pkg.sv
// Shared display-path definitions: Q16.16 constants, converter state encoding
// and the BCD digit type.
package detector_pkg;

  localparam int QtdBitsDecimais = 16;
  localparam int MAX_VAL         = 9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } estado_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module ajuste_bcd
  import detector_pkg::*;
(
  input  bcd_digit_t bcd_i,
  output bcd_digit_t bcd_o
);

  assign bcd_o = (bcd_i >= 4'd5) ? bcd_digit_t'(bcd_i + 4'd3) : bcd_i;

endmodule

// File: rtl/conversor_bin_bcd.sv
// Sequential Q16.16 to four-digit BCD converter (shift-add-3, one bit per clock)
// with start/done handshake; negative inputs read 0000, large ones saturate.
module conversor_bin_bcd #(
  parameter int IN_W      = 32,
  parameter int FRAC_BITS = detector_pkg::QtdBitsDecimais,
  parameter int INT_BITS  = 14,
  parameter int MAX_VAL   = detector_pkg::MAX_VAL
) (
  input  logic            ADC_CLK_10,
  input  logic            clear,
  input  logic            start,
  input  logic [IN_W-1:0] valor,
  output logic            busy,
  output logic            done,
  output logic [3:0]      digit3,
  output logic [3:0]      digit2,
  output logic [3:0]      digit1,
  output logic [3:0]      digit0,
  output logic            overflow,
  output logic            negative
);
  import detector_pkg::*;

  localparam int IP_W  = IN_W - FRAC_BITS;
  localparam int SW    = 16 + INT_BITS;
  localparam int CNT_W = $clog2(INT_BITS + 1);
  localparam logic [IP_W-1:0]     MAX_IP   = IP_W'(MAX_VAL);
  localparam logic [INT_BITS-1:0] MAX_OP   = INT_BITS'(MAX_VAL);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(INT_BITS - 1);

  estado_t             state_q, state_d;
  logic [IP_W-1:0]     cap_q, cap_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d, ov_q, ov_d;
  logic [15:0]         bcd_out_q, bcd_out_d;
  logic                ovf_q, ovf_d, negf_q, negf_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [15:0]         adj_s;
  logic [INT_BITS-1:0] operand_s;
  logic                unused_s;

  // Fraction bits never reach the converter and the adjusted top bit is shifted out.
  assign unused_s = ^{valor[FRAC_BITS-1:0], adj_s[15]};

  for (genvar g = 0; g < 4; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .bcd_i (scratch_q[INT_BITS + 4*g +: 4]),
      .bcd_o (adj_s[4*g +: 4])
    );
  end

  // Next-state and datapath control for the IDLE/LOAD/SHIFT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ov_d      = ov_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    negf_d    = negf_q;
    done_d    = 1'b0;
    operand_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_d   = valor[IN_W-1:FRAC_BITS];
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        neg_d = 1'b0;
        ov_d  = 1'b0;
        if (cap_q[IP_W-1]) begin
          neg_d     = 1'b1;
          operand_s = '0;
        end else if (cap_q > MAX_IP) begin
          ov_d      = 1'b1;
          operand_s = MAX_OP;
        end else begin
          operand_s = cap_q[INT_BITS-1:0];
        end
        scratch_d = {16'h0000, operand_s};
        cnt_d     = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        scratch_d = {adj_s[14:0], scratch_q[INT_BITS-1:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_out_d = scratch_q[SW-1 -: 16];
        ovf_d     = ov_q;
        negf_d    = neg_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; clear wins over any pending start.
  always_ff @(posedge ADC_CLK_10) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      cap_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ov_q      <= 1'b0;
      bcd_out_q <= 16'h0000;
      ovf_q     <= 1'b0;
      negf_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ov_q      <= ov_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
      negf_q    <= negf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digit3   = bcd_out_q[15:12];
  assign digit2   = bcd_out_q[11:8];
  assign digit1   = bcd_out_q[7:4];
  assign digit0   = bcd_out_q[3:0];
  assign overflow = ovf_q;
  assign negative = negf_q;

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Scoreboard bench for conversor_bin_bcd: the driver queues hand-computed
// results, a negedge monitor checks each done pulse against them.
module tb_conversor_bin_bcd;

  logic        clk = 1'b0;
  logic        clear, start;
  logic [31:0] valor;
  logic        busy, done, overflow, negative;
  logic [3:0]  digit3, digit2, digit1, digit0;

  typedef struct {
    logic [15:0] bcd;
    logic        ov;
    logic        neg;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;

  conversor_bin_bcd dut (
    .ADC_CLK_10 (clk),
    .clear      (clear),
    .start      (start),
    .valor      (valor),
    .busy       (busy),
    .done       (done),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .overflow   (overflow),
    .negative   (negative)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare each done pulse with the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_run++;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("digits",       int'({digit3, digit2, digit1, digit0}), int'(e.bcd));
        chk("overflow",     int'(overflow), int'(e.ov));
        chk("negative",     int'(negative), int'(e.neg));
        chk("done_cycle",   cyc, e.cyc);
        chk("busy_cycles",  busy_run, 16);
        chk("busy_at_done", int'(busy), 0);
      end
      busy_run = 0;
    end
  end

  task automatic push_exp(input logic [15:0] bcd, input logic ov, input logic neg, input int at);
    exp_t e;
    e.bcd = bcd; e.ov = ov; e.neg = neg; e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic convert(input logic [31:0] v, input logic [15:0] bcd, input logic ov, input logic neg);
    start = 1'b1;
    valor = v;
    push_exp(bcd, ov, neg, cyc + 17);
    @(negedge clk);
    start = 1'b0;
    valor = $urandom;
    wait_idle();
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b1;
    valor = 32'h0063_0000;
    repeat (3) @(negedge clk);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_digits", int'({digit3, digit2, digit1, digit0}), 0);
    chk("rst_ov",    int'(overflow), 0);
    chk("rst_neg",   int'(negative), 0);
    clear = 1'b0;
    start = 1'b0;
    @(negedge clk);

    convert(32'h0000_0000, 16'h0000, 1'b0, 1'b0);
    convert((32'd1234 << 16) | 32'h0000_FFFF, 16'h1234, 1'b0, 1'b0);
    convert(32'd9999 << 16, 16'h9999, 1'b0, 1'b0);
    convert(32'd10000 << 16, 16'h9999, 1'b1, 1'b0);
    convert(32'h7FFF_0000, 16'h9999, 1'b1, 1'b0);
    convert(32'hFFFF_0000, 16'h0000, 1'b0, 1'b1);
    convert(32'd25 << 16 | 32'h0000_8000, 16'h0025, 1'b0, 1'b0);

    // start while busy is dropped
    start = 1'b1;
    valor = 32'd42 << 16;
    push_exp(16'h0042, 1'b0, 1'b0, cyc + 17);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    valor = 32'd777 << 16;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_digits", int'({digit3, digit2, digit1, digit0}), 16'h0042);
    convert(32'd777 << 16, 16'h0777, 1'b0, 1'b0);

    // clear mid-conversion aborts without done
    start = 1'b1;
    valor = 32'd5678 << 16;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    busy_run = 0;
    chk("clr_busy",   int'(busy), 0);
    chk("clr_digits", int'({digit3, digit2, digit1, digit0}), 0);
    chk("clr_ov",     int'(overflow), 0);
    repeat (20) @(negedge clk);
    convert(32'd5678 << 16, 16'h5678, 1'b0, 1'b0);

    // start held high: back-to-back conversions every 17 cycles
    start = 1'b1;
    valor = 32'd1111 << 16;
    push_exp(16'h1111, 1'b0, 1'b0, cyc + 17);
    push_exp(16'h2222, 1'b0, 1'b0, cyc + 34);
    @(negedge clk);
    valor = 32'd2222 << 16;
    repeat (17) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
